// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns a decoded request into a 32-bit word and
// writes it to instruction memory. Define INSTR_ENC_CHK_EN to flag illegal requests on err.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [3:0]  req_alu,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  input  logic        flush,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [15:0] instr_count,
  output logic        busy,
  output logic        err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] K_R      = 3'd0;
  localparam logic [2:0] K_IARITH = 3'd1;
  localparam logic [2:0] K_LOAD   = 3'd2;
  localparam logic [2:0] K_STORE  = 3'd3;
  localparam logic [2:0] K_BRANCH = 3'd4;
  localparam logic [2:0] K_JAL    = 3'd5;
  localparam logic [2:0] K_LUI    = 3'd6;
  localparam logic [2:0] K_AUIPC  = 3'd7;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {IDLE, ENCODE, WRITE} state_t;

  state_t           state;
  logic [2:0]       kind_q;
  logic [3:0]       alu_q;
  logic [2:0]       f3_q;
  logic [4:0]       rd_q;
  logic [4:0]       rs1_q;
  logic [4:0]       rs2_q;
  logic [31:0]      imm_q;
  logic             we_q;
  logic [IDX_W-1:0] idx;
  logic [2:0]       alu_f3;
  logic [6:0]       alu_f7;
  logic             is_shift;
  logic [31:0]      word;
  logic             illegal;

  assign imem_addr = BASE_ADDR + {{(30-IDX_W){1'b0}}, idx, 2'b00};
  // A flush during WRITE must suppress the write already under way.
  assign imem_we   = we_q & ~flush;

  always_comb begin
    alu_f3   = 3'b000;
    alu_f7   = 7'b0000000;
    is_shift = 1'b0;
    case (alu_q)
      ALU_SUB:  alu_f7 = 7'b0100000;
      ALU_AND:  alu_f3 = 3'b111;
      ALU_OR:   alu_f3 = 3'b110;
      ALU_XOR:  alu_f3 = 3'b100;
      ALU_SLL:  begin alu_f3 = 3'b001; is_shift = 1'b1; end
      ALU_SRL:  begin alu_f3 = 3'b101; is_shift = 1'b1; end
      ALU_SRA:  begin alu_f3 = 3'b101; alu_f7 = 7'b0100000; is_shift = 1'b1; end
      ALU_SLT:  alu_f3 = 3'b010;
      ALU_SLTU: alu_f3 = 3'b011;
      default:  alu_f3 = 3'b000;
    endcase
  end

  always_comb begin
    word = 32'h0;
    case (kind_q)
      K_R:      word = {alu_f7, rs2_q, rs1_q, alu_f3, rd_q, 7'b0110011};
      K_IARITH: begin
        // SUB has no immediate form, so it collapses to ADDI here.
        if (is_shift)
          word = {1'b0, alu_q == ALU_SRA, 5'b00000, imm_q[4:0], rs1_q, alu_f3, rd_q, 7'b0010011};
        else
          word = {imm_q[11:0], rs1_q, alu_f3, rd_q, 7'b0010011};
      end
      K_LOAD:   word = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0000011};
      K_STORE:  word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], 7'b0100011};
      K_BRANCH: word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], 7'b1100011};
      K_JAL:    word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, 7'b1101111};
      K_LUI:    word = {imm_q[31:12], rd_q, 7'b0110111};
      K_AUIPC:  word = {imm_q[31:12], rd_q, 7'b0010111};
      default:  word = 32'h0;
    endcase
  end

`ifdef INSTR_ENC_CHK_EN
  logic err_q;

  function automatic logic fits_signed(input logic [31:0] v, input int n);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (n - 1));
    return (hi == 32'h0) || (hi == 32'hFFFF_FFFF);
  endfunction

  always_comb begin
    illegal = 1'b0;
    case (kind_q)
      K_R:      illegal = alu_q > ALU_SLTU;
      K_IARITH: illegal = (alu_q > ALU_SLTU) || (alu_q == ALU_SUB) ||
                          (is_shift ? (imm_q[31:5] != 27'h0) : !fits_signed(imm_q, 12));
      K_LOAD:   illegal = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111) ||
                          !fits_signed(imm_q, 12);
      K_STORE:  illegal = (f3_q > 3'b010) || !fits_signed(imm_q, 12);
      K_BRANCH: illegal = (f3_q == 3'b010) || (f3_q == 3'b011) || imm_q[0] ||
                          !fits_signed(imm_q, 13);
      K_JAL:    illegal = imm_q[0] || !fits_signed(imm_q, 21);
      default:  illegal = 1'b0;
    endcase
  end

  // err occupies the WRITE slot that a legal request would have used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (flush)
      err_q <= 1'b0;
    else
      err_q <= (state == ENCODE) && illegal;
  end

  assign err = err_q;
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      busy        <= 1'b0;
      we_q        <= 1'b0;
      idx         <= '0;
      instr_count <= 16'h0;
      imem_wdata  <= 32'h0;
      kind_q      <= 3'h0;
      alu_q       <= 4'h0;
      f3_q        <= 3'h0;
      rd_q        <= 5'h0;
      rs1_q       <= 5'h0;
      rs2_q       <= 5'h0;
      imm_q       <= 32'h0;
    end else if (flush) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      we_q        <= 1'b0;
      idx         <= '0;
      instr_count <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready is still low on the first edge out of reset.
          if (req_valid && req_ready) begin
            kind_q    <= req_kind;
            alu_q     <= req_alu;
            f3_q      <= req_funct3;
            rd_q      <= req_rd;
            rs1_q     <= req_rs1;
            rs2_q     <= req_rs2;
            imm_q     <= req_imm;
            state     <= ENCODE;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ENCODE: begin
          imem_wdata <= word;
          we_q       <= ~illegal;
          state      <= WRITE;
        end
        WRITE: begin
          we_q      <= 1'b0;
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          if (we_q) begin
            idx <= idx + 1'b1;
            if (instr_count != 16'hFFFF)
              instr_count <= instr_count + 16'd1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          we_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
